// File: rtl/mean_square_window_if.sv
// Sample-in / result-out bundle for the windowed mean-square stage.
// master drives samples and ready; slave is the estimator.
interface mean_square_window_if #(
   parameter int DATA_W = 8,
   parameter int OUT_W  = 8
);
   logic                     i_valid;
   logic signed [DATA_W-1:0] i_data;
   logic                     i_ready;
   logic                     o_valid;
   logic [OUT_W-1:0]         o_data;
   logic                     o_overrun;

   modport master (
      output i_valid, i_data, i_ready,
      input  o_valid, o_data, o_overrun
   );

   modport slave (
      input  i_valid, i_data, i_ready,
      output o_valid, o_data, o_overrun
   );
endinterface

// File: rtl/mean_square_window.sv
// Windowed mean-square estimator: square, sum 2**LOG2_N samples,
// scale to OUT_W bits and hold on a valid/ready output register.
module mean_square_window #(
   parameter int DATA_W = 8,
   parameter int LOG2_N = 4,
   parameter int OUT_W  = 8
) (
   input logic                 i_clk,
   input logic                 i_reset,
   mean_square_window_if.slave bus
);
   localparam int SQ_W  = 2*DATA_W-1;
   localparam int ACC_W = SQ_W+LOG2_N;
   localparam int SHIFT = ACC_W-OUT_W;

   logic [DATA_W-1:0] raw;
   logic [DATA_W-1:0] mag;
   logic [SQ_W-1:0]   sq;
   logic [SQ_W-1:0]   sq_q;
   logic              sq_v;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  sum;
   logic [LOG2_N-1:0] cnt;
   logic              last;
   logic              load;
   logic [OUT_W-1:0]  result;

   // |x| fits DATA_W unsigned bits, so the square fits SQ_W exactly
   assign raw = bus.i_data;
   assign mag = raw[DATA_W-1] ? (~raw + DATA_W'(1)) : raw;
   assign sq  = SQ_W'(mag) * SQ_W'(mag);

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sq_q <= '0;
         sq_v <= 1'b0;
      end else begin
         sq_v <= bus.i_valid;
         if (bus.i_valid)
            sq_q <= sq;
      end
   end

   assign sum    = acc + ACC_W'(sq_q);
   assign last   = (cnt == '1);
   assign load   = sq_v && last;
   assign result = sum[SHIFT +: OUT_W];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         acc <= '0;
         cnt <= '0;
      end else if (sq_v) begin
         if (last) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= sum;
            cnt <= cnt + LOG2_N'(1);
         end
      end
   end

   // newest result wins when the previous one was never taken
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         bus.o_valid   <= 1'b0;
         bus.o_data    <= '0;
         bus.o_overrun <= 1'b0;
      end else if (load) begin
         bus.o_valid <= 1'b1;
         bus.o_data  <= result;
         if (bus.o_valid && !bus.i_ready)
            bus.o_overrun <= 1'b1;
      end else if (bus.o_valid && bus.i_ready) begin
         bus.o_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mean_square_window.sv
// Directed bench for mean_square_window with hand-computed results.
// Window length 16, scale >>11: +64 -> 32, -128 -> 128.
module tb_mean_square_window;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_pulse = 0;

   mean_square_window_if #(.DATA_W(8), .OUT_W(8)) bus ();

   mean_square_window #(.DATA_W(8), .LOG2_N(4), .OUT_W(8)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (bus.o_valid)
         n_pulse++;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int isqrt(input int v);
      int r = 0;
      while ((r+1)*(r+1) <= v)
         r++;
      return r;
   endfunction

   task automatic window(input logic signed [7:0] a,
                         input logic signed [7:0] b,
                         input bit gap);
      for (int i = 0; i < 16; i++) begin
         bus.i_data  = i[0] ? b : a;
         bus.i_valid = 1'b1;
         step();
         if (gap && i < 15) begin
            bus.i_valid = 1'b0;
            bus.i_data  = 8'sd127;
            step();
         end
      end
      bus.i_valid = 1'b0;
   endtask

   task automatic check_win(input string tag, input int exp);
      chk({tag, "_early"}, n_pulse, 0);
      chk({tag, "_lat0"}, int'(bus.o_valid), 0);
      step();
      chk({tag, "_valid"}, int'(bus.o_valid), 1);
      chk({tag, "_data"}, int'(bus.o_data), exp);
      step();
      chk({tag, "_drop"}, int'(bus.o_valid), 0);
      chk({tag, "_pulses"}, n_pulse, 1);
      n_pulse = 0;
   endtask

   initial begin
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      bus.i_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      chk("rst_valid", int'(bus.o_valid), 0);
      chk("rst_data", int'(bus.o_data), 0);
      chk("rst_overrun", int'(bus.o_overrun), 0);
      n_pulse = 0;

      window(8'sd64, 8'sd64, 1'b0);
      check_win("pos64", 32);
      chk("sqrt32", isqrt(int'(bus.o_data)), 5);

      window(-8'sd128, -8'sd128, 1'b0);
      check_win("neg128", 128);
      chk("sqrt128", isqrt(int'(bus.o_data)), 11);

      window(8'sd0, 8'sd0, 1'b0);
      check_win("zero", 0);

      window(8'sd1, -8'sd1, 1'b0);
      check_win("alt1", 0);

      window(8'sd64, 8'sd64, 1'b1);
      check_win("gap64", 32);

      bus.i_ready = 1'b0;
      window(8'sd64, 8'sd64, 1'b0);
      window(-8'sd128, -8'sd128, 1'b0);
      step();
      step();
      chk("ovr_valid", int'(bus.o_valid), 1);
      chk("ovr_data", int'(bus.o_data), 128);
      chk("ovr_flag", int'(bus.o_overrun), 1);
      bus.i_ready = 1'b1;
      step();
      chk("ovr_drain", int'(bus.o_valid), 0);
      step();
      step();
      chk("ovr_sticky", int'(bus.o_overrun), 1);

      for (int i = 0; i < 10; i++) begin
         bus.i_data  = 8'sd127;
         bus.i_valid = 1'b1;
         step();
      end
      bus.i_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_overrun", int'(bus.o_overrun), 0);
      chk("mid_rst_valid", int'(bus.o_valid), 0);
      n_pulse = 0;
      window(8'sd64, 8'sd64, 1'b0);
      check_win("post_rst", 32);
      chk("post_rst_overrun", int'(bus.o_overrun), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
